// File: rtl/fpu_ctrl_pkg.sv
// Shared constants and FSM encoding for the FPU arbiter.
// Imported by the arbiter top and its round-robin picker.
package fpu_ctrl_pkg;

  localparam int FP_W = 32;
  localparam int CNT_W = 4;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Searches req from ptr upward, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one FP mul/div unit between requesters,
// one operation in flight, round-robin grant, valid/ready return.
module fpu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 2,
  parameter int FP_W    = fpu_ctrl_pkg::FP_W,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_op,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [FP_W-1:0]         rsp_value,
  output logic [FP_W-1:0]         fpu_a,
  output logic [FP_W-1:0]         fpu_b,
  output logic                    fpu_op,
  input  logic [FP_W-1:0]         fpu_value,
  output logic                    busy,
  output logic [IW-1:0]           grant_id
);

  import fpu_ctrl_pkg::*;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gid_q, gid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FP_W-1:0]      a_q, a_d;
  logic [FP_W-1:0]      b_q, b_d;
  logic [FP_W-1:0]      val_q, val_d;
  logic                 op_q, op_d;
  logic [NUM_REQ-1:0]   rv_q, rv_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_ready = (state_q == IDLE) ? pick_gnt : '0;
  assign rsp_valid = rv_q;
  assign rsp_value = val_q;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign fpu_op    = op_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gid_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    val_d   = val_q;
    rv_d    = rv_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          a_d     = req_a[int'(pick_idx)*FP_W +: FP_W];
          b_d     = req_b[int'(pick_idx)*FP_W +: FP_W];
          op_d    = req_op[pick_idx];
          gid_d   = pick_idx;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          val_d       = fpu_value;
          rv_d        = '0;
          rv_d[gid_q] = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // next search starts just past the requester served last
        if (rsp_ready[gid_q]) begin
          rv_d    = '0;
          ptr_d   = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      val_q   <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      val_q   <= val_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed + random stimulus against a
// transaction-level model of the shared-FPU arbiter.
module tb_fpu_arbiter;

  import fpu_ctrl_pkg::*;

  localparam int N   = 2;
  localparam int LAT = 2;
  localparam int W   = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, req_op;
  logic [N-1:0]   rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   rsp_value, fpu_a, fpu_b, fpu_value;
  logic           fpu_op, busy;
  logic [0:0]     grant_id;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(
    .NUM_REQ (N),
    .LATENCY (LAT),
    .FP_W    (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_value (rsp_value),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_op    (fpu_op),
    .fpu_value (fpu_value),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == '0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    logic        up;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'd0};
    e  = int'(d[62:52]) - 896;
    up = d[28] && ((|d[27:0]) || d[29]);
    m  = {2'b01, d[51:29]} + 25'(up);
    if (m[24]) begin
      e = e + 1;
      m = m >> 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic op);
    real ra, rb;
    ra = sp2real(a);
    rb = sp2real(b);
    return real2sp(op == OP_DIV ? ra / rb : ra * rb);
  endfunction

  // FP unit: compute from held operands, one register stage -> LAT=2
  logic [W-1:0] fpu_pipe;
  always @(posedge clk) fpu_pipe <= fp_model(fpu_a, fpu_b, fpu_op);
  assign fpu_value = fpu_pipe;

  bit          m_known = 1'b0;
  bit          m_busy;
  int          m_gid, m_acc, m_ptr, cyc = 0;
  logic [31:0] m_a, m_b, m_exp, m_val;
  logic        m_op;

  function automatic int rr_winner();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_gid = 0; m_acc = 0; m_ptr = 0;
    m_a = '0; m_b = '0; m_op = 1'b0; m_exp = '0; m_val = '0;
  endtask

  task automatic cycle();
    int         g;
    logic [N-1:0] e_rdy, e_rv;
    @(negedge clk);
    if (m_known) begin
      g = m_busy ? -1 : rr_winner();
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      e_rv = '0;
      if (m_busy && cyc - m_acc >= LAT) e_rv[m_gid] = 1'b1;
      chk("req_ready", req_ready, e_rdy);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_value", rsp_value, m_val);
      chk("fpu_a", fpu_a, m_a);
      chk("fpu_b", fpu_b, m_b);
      chk("fpu_op", fpu_op, m_op);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_gid);
    end
    if (reset) begin
      model_clear();
      m_known = 1'b1;
    end else if (m_known) begin
      if (!m_busy) begin
        g = rr_winner();
        if (g >= 0) begin
          m_busy = 1;
          m_gid  = g;
          m_acc  = cyc + 1;
          m_a    = req_a[g*W +: W];
          m_b    = req_b[g*W +: W];
          m_op   = req_op[g];
          m_exp  = fp_model(m_a, m_b, m_op);
        end
      end else if (cyc - m_acc >= LAT) begin
        if (rsp_ready[m_gid]) begin
          m_busy = 0;
          m_ptr  = (m_gid + 1) % N;
        end
      end else if (cyc + 1 - m_acc == LAT) begin
        m_val = m_exp;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]     = 1'b1;
    req_op[i]        = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    while (!rsp_valid[i] && n < 30) begin
      cycle();
      n++;
    end
    chk("wait_rsp", rsp_valid[i], 1'b1);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(145, 110));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          got[$];
    logic [31:0] v;
    logic [N-1:0] acc;

    reset = 1'b1; req_valid = '0; req_op = '0;
    req_a = '0; req_b = '0; rsp_ready = '0;
    @(posedge clk); #1;
    cycle();
    cycle();
    chk("rst_ctrl", {rsp_valid, req_ready, busy, fpu_op, grant_id}, '0);
    chk("rst_data", rsp_value | fpu_a | fpu_b, '0);
    reset = 1'b0;

    // single divide
    set_req(0, OP_DIV, 32'h447a0000, 32'hc1200000);
    #1;
    chk("t1_ready", req_ready, 2'b01);
    cycle();
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      chk("t1_busy", busy, 1'b1);
      cycle();
      n++;
    end
    chk("t1_latency", n, LAT);
    chk("t1_value", rsp_value, 32'hC2C80000);
    rsp_ready = 2'b01;
    cycle();
    rsp_ready = '0;
    chk("t1_idle", busy, 1'b0);

    // single multiply
    set_req(1, OP_MUL, 32'h42000000, 32'h42000000);
    cycle();
    req_valid[1] = 1'b0;
    chk("t2_gid", grant_id, 1'b1);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      chk("t2_hold_a", fpu_a, 32'h42000000);
      chk("t2_hold_b", fpu_b, 32'h42000000);
      cycle();
      n++;
    end
    chk("t2_valid", rsp_valid, 2'b10);
    chk("t2_value", rsp_value, 32'h44800000);
    rsp_ready = 2'b10;
    cycle();
    rsp_ready = '0;

    // contention from reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_req(0, OP_MUL, rnd_fp(), rnd_fp());
    set_req(1, OP_DIV, rnd_fp(), rnd_fp());
    rsp_ready = 2'b11;
    n = 0;
    while (got.size() < 4 && n < 40) begin
      #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) got.push_back(i);
      cycle();
      n++;
    end
    chk("t3_grants", got.size(), 4);
    foreach (got[i]) chk("t3_order", got[i], i % 2);
    req_valid = '0;
    repeat (6) cycle();

    // backpressure
    rsp_ready = '0;
    set_req(0, OP_MUL, rnd_fp(), rnd_fp());
    cycle();
    req_valid[0] = 1'b0;
    set_req(1, OP_DIV, rnd_fp(), rnd_fp());
    wait_rsp(0);
    v = rsp_value;
    rsp_ready = 2'b10;
    repeat (5) begin
      cycle();
      chk("t4_valid", rsp_valid, 2'b01);
      chk("t4_value", rsp_value, v);
      chk("t4_ready", req_ready, 2'b00);
    end
    rsp_ready = 2'b01;
    cycle();
    rsp_ready = '0;
    #1;
    chk("t4_next", req_ready, 2'b10);
    cycle();
    req_valid[1] = 1'b0;
    wait_rsp(1);
    rsp_ready = 2'b10;
    cycle();

    // reset mid-operation, pointer left at 1 beforehand
    rsp_ready = 2'b01;
    set_req(0, OP_MUL, rnd_fp(), rnd_fp());
    cycle();
    req_valid[0] = 1'b0;
    wait_rsp(0);
    cycle();
    rsp_ready = '0;
    set_req(0, OP_DIV, rnd_fp(), rnd_fp());
    cycle();
    req_valid[0] = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_rst_ctrl", {busy, rsp_valid, fpu_op, grant_id}, '0);
    chk("t5_rst_data", fpu_a | fpu_b | rsp_value, '0);
    repeat (LAT + 3) begin
      cycle();
      chk("t5_no_rsp", rsp_valid, 2'b00);
    end
    set_req(0, OP_MUL, rnd_fp(), rnd_fp());
    set_req(1, OP_MUL, rnd_fp(), rnd_fp());
    #1;
    chk("t5_ptr0", req_ready, 2'b01);
    cycle();
    req_valid = '0;
    wait_rsp(0);
    rsp_ready = 2'b01;
    cycle();
    rsp_ready = '0;

    // late arrival during another requester's WAIT
    set_req(0, OP_DIV, rnd_fp(), rnd_fp());
    cycle();
    req_valid[0] = 1'b0;
    set_req(1, OP_MUL, rnd_fp(), rnd_fp());
    #1;
    chk("t6_wait_ready", req_ready, 2'b00);
    wait_rsp(0);
    chk("t6_resp_ready", req_ready, 2'b00);
    rsp_ready = 2'b01;
    cycle();
    rsp_ready = '0;
    #1;
    chk("t6_late", req_ready, 2'b10);
    cycle();
    req_valid[1] = 1'b0;
    chk("t6_gid", grant_id, 1'b1);
    wait_rsp(1);
    rsp_ready = 2'b10;
    cycle();
    rsp_ready = '0;

    // random traffic, requests held until accepted
    for (int t = 0; t < 400; t++) begin
      rsp_ready = N'($urandom);
      #1;
      acc = req_valid & req_ready;
      cycle();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(3) == 0)
          set_req(i, 1'($urandom), rnd_fp(), rnd_fp());
      end
    end
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (8) cycle();
    chk("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Shares one floating-point execution unit (FloatingMultiply / FloatingDivide behind an op select) between NUM_REQ requesters. Arbitration is round-robin. At most one operation is in flight at a time. The block latches the winner's operands, holds them stable on the unit for a fixed LATENCY, captures the result, and returns it to the winner with a valid/ready handshake. It sits between the instruction-issue logic and the FP datapath.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
LATENCY, 2, clock cycles from operands presented on fpu_a/fpu_b to fpu_value valid (1..15).
FP_W, 32, IEEE-754 single word width.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request; must be held until accepted.
req_ready  out  NUM_REQ  one-hot accept, combinational, asserted only in IDLE for the grant winner.
req_op  in  NUM_REQ  per-requester op: 0 = multiply, 1 = divide.
req_a  in  NUM_REQ*FP_W  packed operand A; requester i in bits [i*FP_W +: FP_W].
req_b  in  NUM_REQ*FP_W  packed operand B, same packing.
rsp_valid  out  NUM_REQ  one-hot result valid for the granted requester.
rsp_ready  in  NUM_REQ  per-requester result accept.
rsp_value  out  FP_W  result word, shared by all requesters; qualified by rsp_valid.
fpu_a  out  FP_W  operand A to the FP unit.
fpu_b  out  FP_W  operand B to the FP unit.
fpu_op  out  1  op select to the FP unit.
fpu_value  in  FP_W  result from the FP unit.
busy  out  1  high in WAIT and RESP.
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset: state = IDLE; req_ready = 0; rsp_valid = 0; rsp_value = 0; fpu_a = 0; fpu_b = 0; fpu_op = 0; busy = 0; grant_id = 0; round-robin pointer = 0; counter = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Search req_valid starting at the pointer index and wrapping modulo NUM_REQ. The first set bit is the winner g.
  - req_ready[g] = 1 in the same cycle (accept handshake = req_valid[g] & req_ready[g]).
  - On that edge: fpu_a <= req_a[g], fpu_b <= req_b[g], fpu_op <= req_op[g], grant_id <= g, counter <= LATENCY-1, state <= WAIT.
  - If no req_valid bit is set, stay in IDLE.
- WAIT:
  - fpu_a, fpu_b and fpu_op are held constant.
  - While counter != 0, decrement it.
  - When counter == 0: rsp_value <= fpu_value, rsp_valid[grant_id] <= 1, state <= RESP.
  - Timing: with the accept on edge 0, the result is captured on edge LATENCY and rsp_valid is first high in cycle LATENCY.
- RESP:
  - rsp_valid and rsp_value are held stable until rsp_ready[grant_id].
  - On the handshake edge: rsp_valid <= 0, pointer <= (grant_id+1) mod NUM_REQ, state <= IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Throughput: one operation per LATENCY+2 cycles at best. A new accept is never made in the same cycle as a response handshake.
- Fairness: a requester held continuously valid is granted within NUM_REQ operations.
- req_ready is 0 in WAIT and RESP. Requests arriving then wait; they are not queued inside the block.
- Reset mid-operation: the in-flight operation is abandoned, no response is produced, and all outputs return to reset values on the next edge.
- The block performs no FP arithmetic or NaN/denormal handling. fpu_value is passed through bit-exact.

Decomposition:
- Package fpu_ctrl_pkg holds:
  - constants OP_MUL = 1'b0 and OP_DIV = 1'b1;
  - FP_W;
  - the state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2).
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any.
- The FSM, operand registers and counter stay in fpu_arbiter.
- The bench attaches a fixed-latency model of FloatingMultiply / FloatingDivide at LATENCY.

Test Plan:
1. Single divide: requester 0, op = 1, a = 0x447a0000 (1000), b = 0xc1200000 (-10) → req_ready[0] in cycle 0; rsp_valid[0] in cycle LATENCY; rsp_value = 0xC2C80000 (-100); busy high from cycle 1 through the handshake.
2. Single multiply: requester 1, op = 0, a = b = 0x42000000 (32) → rsp_valid[1] with rsp_value = 0x44800000 (1024); fpu_a and fpu_b stable for the whole of WAIT.
3. Contention: both requesters valid continuously from reset → grants alternate 0, 1, 0, 1; grant_id matches; each result is routed only to its own rsp_valid bit.
4. Backpressure: rsp_ready held low for 5 cycles → rsp_valid and rsp_value stay constant, req_ready stays 0 for the pending requester, and no new grant occurs until the handshake.
5. Reset mid-operation: assert reset in cycle 1 of WAIT → next cycle all outputs are 0 and state is IDLE; no rsp_valid ever appears for the abandoned operation; a following request completes normally with pointer starting at 0.
6. Late arrival: requester 1 asserts req_valid during requester 0's WAIT → requester 1 is accepted in the first IDLE cycle after requester 0's response handshake.
